control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port run, input, 1 bit: enables instruction sequencing.
REQ-004 The block SHALL have the port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have the port imem_addr, output, 8 bits: byte address, equal to the current pc.
REQ-006 The block SHALL have the port imem_ack, input, 1 bit: imem_data is valid this cycle.
REQ-007 The block SHALL have the port imem_data, input, 8 bits: instruction byte; [7:4] opcode, [3:2] rx index, [1:0] ry index.
REQ-008 The block SHALL have the ports alu_op, alu_rx, alu_ry and alu_mem, each output, 4 bits: operands driven to the ALU.
REQ-009 The block SHALL have the ports alu_out (input, 4 bits), alu_z (input, 1 bit) and alu_n (input, 1 bit): ALU result and flags.
REQ-010 The block SHALL have the ports flag_z and flag_n, each output, 1 bit: latched flags.
REQ-011 The block SHALL have the port pc, output, 8 bits: program counter.
REQ-012 The block SHALL have the port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have the ports dbg_sel (input, 2 bits) and dbg_data (output, 4 bits): combinational read of register r[dbg_sel].

Function
REQ-014 The block SHALL contain four internal 4-bit registers, r0..r3.
REQ-015 The FSM SHALL have the states IDLE, FETCH, FETCH2, EXEC and WB.
REQ-016 In IDLE, the FSM SHALL go to FETCH when run=1 and stay in IDLE otherwise.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; on imem_ack=1, imem_data SHALL be captured into the instruction register.
REQ-018 On that capture, the FSM SHALL go to FETCH2 if imem_data[7]=1 and to EXEC otherwise; with imem_ack=0 it SHALL stay in FETCH.
REQ-019 In FETCH, imem_addr SHALL remain stable until the ack.
REQ-020 In FETCH2, imem_req SHALL be 1 and imem_addr SHALL equal pc+1 (mod 256).
REQ-021 On imem_ack=1 in FETCH2, imem_data[3:0] SHALL be captured as the immediate and the FSM SHALL go to EXEC; imem_data[7:4] in that byte SHALL be ignored.
REQ-022 imem_req SHALL be 0 in IDLE, EXEC and WB.
REQ-023 The outputs alu_op, alu_rx, alu_ry and alu_mem SHALL be registered values, valid from EXEC entry through WB.
REQ-024 Those outputs SHALL be: alu_op = opcode, alu_rx = r[rx], alu_ry = r[ry], alu_mem = the immediate for two-byte instructions and 4'b0000 otherwise.
REQ-025 EXEC SHALL last exactly 1 cycle, allowing the combinational ALU to settle, and then go to WB.
REQ-026 In WB, r[rx] SHALL be loaded with alu_out, and flag_z and flag_n SHALL be loaded with alu_z and alu_n.
REQ-027 In WB, pc SHALL advance by 1 (one-byte instruction) or 2 (two-byte instruction), modulo 256.
REQ-028 pc SHALL wrap from 0xFF to 0x00 on +1, and from 0xFF to 0x01 or from 0xFE to 0x00 on +2.
REQ-029 Leaving WB, the FSM SHALL go to FETCH if run=1 and to IDLE if run=0.
REQ-030 Deasserting run mid-instruction SHALL NOT abort the instruction; it SHALL complete through WB.
REQ-031 Latency with a zero-wait memory SHALL be 3 cycles per one-byte instruction and 4 cycles per two-byte instruction.
REQ-032 When rx=ry, both alu_rx and alu_ry SHALL carry the pre-write value of that register.
REQ-033 r[rx] SHALL only be written in WB; a register is never written twice per instruction.
REQ-034 dbg_data SHALL reflect the register contents as currently stored, including updates made in the same WB edge, on the following cycle.

Reset
REQ-035 rst_n=0 SHALL immediately, without clk, force: state=IDLE, pc=0x00, r0..r3=0, flag_z=0, flag_n=0, imem_req=0, alu_op/alu_rx/alu_ry/alu_mem=0, busy=0.
REQ-036 Reset asserted mid-instruction SHALL discard that instruction with no register or flag write.
REQ-037 After rst_n rises, the first FETCH SHALL occur on the first clk edge with run=1.

Verification
REQ-038 Zero-wait memory, run=1, imem_data=8'h1_6 (rx=1, ry=2), bench drives alu_out=4'b0110, alu_z=0, alu_n=0 -> imem_req for 1 cycle, r1=0110, pc 0x00->0x01 after 3 cycles, flag_z=0, flag_n=0.
REQ-039 Two-byte instruction: byte0=8'h84, byte1=8'hF9, alu_out=4'b1000, alu_n=1 -> alu_mem=1001 in EXEC, r1=1000, flag_n=1, pc advances by 2 in 4 cycles.
REQ-040 imem_ack held low 3 cycles in FETCH -> imem_req stays high with imem_addr constant; instruction completes 3 cycles later than the zero-wait case.
REQ-041 pc=0xFF with a one-byte instruction -> pc=0x00 after WB; pc=0xFF with a two-byte instruction -> second fetch at 0x00 and pc=0x01 after WB.
REQ-042 run dropped during EXEC -> WB still writes, FSM enters IDLE, busy=0 next cycle, imem_req stays 0.
REQ-043 rst_n pulsed low during EXEC -> all outputs zero immediately, target register unchanged (0), pc=0x00.

Source files
------------

// File: rtl/control_unit_if.sv
// control_unit_if -- instruction-memory handshake and ALU operand/result bus.
//
//   imem_req   : read request, high while an instruction byte is wanted
//   imem_addr  : byte address of the requested instruction byte
//   imem_ack   : imem_data is valid this cycle
//   imem_data  : instruction byte ([7:4] opcode, [3:2] rx, [1:0] ry)
//   alu_op     : opcode presented to the ALU
//   alu_rx     : value of r[rx]
//   alu_ry     : value of r[ry]
//   alu_mem    : immediate nibble (zero for one-byte instructions)
//   alu_out    : ALU result
//   alu_z      : ALU zero flag
//   alu_n      : ALU negative flag
//
// master = control unit side, slave = memory / ALU side.
interface control_unit_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] alu_op;
  logic [3:0] alu_rx;
  logic [3:0] alu_ry;
  logic [3:0] alu_mem;
  logic [3:0] alu_out;
  logic       alu_z;
  logic       alu_n;

  modport master (
    output imem_req, imem_addr, alu_op, alu_rx, alu_ry, alu_mem,
    input  imem_ack, imem_data, alu_out, alu_z, alu_n
  );

  modport slave (
    input  imem_req, imem_addr, alu_op, alu_rx, alu_ry, alu_mem,
    output imem_ack, imem_data, alu_out, alu_z, alu_n
  );
endinterface

// File: rtl/control_unit.sv
// control_unit -- sequencer for a tiny 4-register, 4-bit machine.
//
// Fetches one- or two-byte instructions, presents registered operands to an
// external combinational ALU, and writes the result back to r[rx].
//
// Ports:
//   clk       : clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   run       : enables instruction sequencing
//   bus       : instruction-memory handshake and ALU bus (control_unit_if.master)
//   flag_z    : latched ALU zero flag
//   flag_n    : latched ALU negative flag
//   pc        : program counter (byte address)
//   busy      : high whenever the sequencer is not idle
//   dbg_sel   : register index for the debug read port
//   dbg_data  : combinational read of r[dbg_sel]
module control_unit (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  control_unit_if.master        bus,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic [7:0]            pc,
  output logic                  busy,
  input  logic [1:0]            dbg_sel,
  output logic [3:0]            dbg_data
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH2,
    EXEC,
    WB
  } state_t;

  state_t     state;
  logic [3:0] r [4];
  logic [7:0] ir;       // first instruction byte; ir[7] marks a two-byte instruction
  logic [7:0] pc_next;

  assign pc_next  = pc + (ir[7] ? 8'd2 : 8'd1);
  assign busy     = (state != IDLE);
  assign dbg_data = r[dbg_sel];

  // NOTE: every register below is state, so it is written only with
  // non-blocking assignments; reads within the block see pre-edge values,
  // which is what gives rx=ry both operands the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= 8'h00;
      ir            <= 8'h00;
      flag_z        <= 1'b0;
      flag_n        <= 1'b0;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= 8'h00;
      bus.alu_op    <= 4'h0;
      bus.alu_rx    <= 4'h0;
      bus.alu_ry    <= 4'h0;
      bus.alu_mem   <= 4'h0;
      // NOTE: the register file is four flops, not a RAM, and must read as
      // zero straight out of reset, so it is cleared here like any register.
      for (int i = 0; i < 4; i++) r[i] <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state         <= FETCH;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
          end
        end

        FETCH: begin
          if (bus.imem_ack) begin
            ir <= bus.imem_data;
            if (bus.imem_data[7]) begin
              state         <= FETCH2;
              bus.imem_addr <= pc + 8'd1;
            end else begin
              state        <= EXEC;
              bus.imem_req <= 1'b0;
              bus.alu_op   <= bus.imem_data[7:4];
              bus.alu_rx   <= r[bus.imem_data[3:2]];
              bus.alu_ry   <= r[bus.imem_data[1:0]];
              bus.alu_mem  <= 4'h0;
            end
          end
        end

        FETCH2: begin
          // Only the low nibble of the second byte is meaningful.
          if (bus.imem_ack) begin
            state        <= EXEC;
            bus.imem_req <= 1'b0;
            bus.alu_op   <= ir[7:4];
            bus.alu_rx   <= r[ir[3:2]];
            bus.alu_ry   <= r[ir[1:0]];
            bus.alu_mem  <= bus.imem_data[3:0];
          end
        end

        EXEC: begin
          // One cycle for the external ALU to settle on the held operands.
          state <= WB;
        end

        WB: begin
          r[ir[3:2]] <= bus.alu_out;
          flag_z     <= bus.alu_z;
          flag_n     <= bus.alu_n;
          pc         <= pc_next;
          if (run) begin
            state         <= FETCH;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc_next;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
//
// An instruction-level reference model tracks the architectural state
// (registers, pc, flags) and which phase of an instruction is in flight;
// every cycle the DUT outputs are compared to it at the falling edge.
// Directed sequences pin the model with hand-computed literal values, then
// a randomized run (random code, wait states, run toggling, a mid-run
// reset) exercises the rest.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       flag_z;
  logic       flag_n;
  logic [7:0] pc;
  logic       busy;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  control_unit_if bus ();

  control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .bus      (bus),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .pc       (pc),
    .busy     (busy),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- environment ----------------
  logic [7:0] mem [256];
  int         fixed_wait = 0;   // <0 : random wait states
  int         wait_left  = 0;
  bit         force_alu  = 1'b0;
  logic [3:0] f_out;
  logic       f_z, f_n;
  int         req_seen = 0;

  // ---------------- reference model ----------------
  logic [3:0] m_r [4];
  logic [7:0] m_pc;
  logic       m_fz, m_fn;
  bit         m_fetching;       // waiting for an instruction byte
  logic       m_byteidx;        // which byte of the instruction is wanted
  int         m_exec;           // 2: operands just presented, 1: write-back cycle
  logic [3:0] m_op, m_imm, m_ax, m_ay;
  logic [1:0] m_xi, m_yi;
  bit         m_two;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reg(input string name, input logic [1:0] idx, input logic [3:0] exp);
    dbg_sel = idx;
    #1;
    check(name, {4'h0, dbg_data}, {4'h0, exp});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
    m_pc = 8'h00; m_fz = 1'b0; m_fn = 1'b0;
    m_fetching = 1'b0; m_byteidx = 1'b0; m_exec = 0;
    m_op = 4'h0; m_imm = 4'h0; m_ax = 4'h0; m_ay = 4'h0;
    m_xi = 2'd0; m_yi = 2'd0; m_two = 1'b0;
    wait_left = 0;
  endtask

  task automatic start_fetch(input logic idx);
    m_fetching = 1'b1;
    m_byteidx  = idx;
    if (fixed_wait >= 0) wait_left = fixed_wait;
    else begin
      wait_left = $urandom_range(0, 4);
      if (wait_left > 2) wait_left = 0;
    end
  endtask

  task automatic launch();
    m_fetching = 1'b0;
    m_ax = m_r[m_xi];
    m_ay = m_r[m_yi];
    m_exec = 2;
  endtask

  // Advance the model across one rising edge, using the inputs the bench drives.
  task automatic model_step();
    if (m_exec == 1) begin
      m_r[m_xi] = bus.alu_out;
      m_fz = bus.alu_z;
      m_fn = bus.alu_n;
      m_pc = m_pc + (m_two ? 8'd2 : 8'd1);
      m_exec = 0;
      if (run) start_fetch(1'b0);
    end else if (m_exec == 2) begin
      m_exec = 1;
    end else if (m_fetching) begin
      if (bus.imem_ack) begin
        if (!m_byteidx) begin
          m_op  = bus.imem_data[7:4];
          m_xi  = bus.imem_data[3:2];
          m_yi  = bus.imem_data[1:0];
          m_two = bus.imem_data[7];
          m_imm = 4'h0;
          if (m_two) start_fetch(1'b1);
          else       launch();
        end else begin
          m_imm = bus.imem_data[3:0];
          launch();
        end
      end
    end else if (run) begin
      start_fetch(1'b0);
    end
  endtask

  // Compare every DUT output against the model; called at a falling edge.
  task automatic compare_all();
    check("busy", {7'd0, busy}, {7'd0, (m_fetching || (m_exec != 0))});
    check("imem_req", {7'd0, bus.imem_req}, {7'd0, m_fetching});
    if (m_fetching) check("imem_addr", bus.imem_addr, m_pc + {7'd0, m_byteidx});
    check("pc", pc, m_pc);
    check("flags", {6'd0, flag_z, flag_n}, {6'd0, m_fz, m_fn});
    if (m_exec != 0) begin
      check("alu_op",  {4'h0, bus.alu_op},  {4'h0, m_op});
      check("alu_rx",  {4'h0, bus.alu_rx},  {4'h0, m_ax});
      check("alu_ry",  {4'h0, bus.alu_ry},  {4'h0, m_ay});
      check("alu_mem", {4'h0, bus.alu_mem}, {4'h0, (m_two ? m_imm : 4'h0)});
    end
    if (bus.imem_req) req_seen++;
    dbg_sel = 2'($urandom_range(0, 3));
    #1;
    check("dbg_data", {4'h0, dbg_data}, {4'h0, m_r[dbg_sel]});
  endtask

  // One clock cycle: compare, drive memory/ALU/run, step the model.
  task automatic cycle(input bit run_in);
    logic [3:0] o;
    compare_all();
    run = run_in;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 8'($urandom);
    if (m_fetching) begin
      if (wait_left > 0) wait_left--;
      else begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem[m_pc + {7'd0, m_byteidx}];
      end
    end
    if (force_alu) begin
      bus.alu_out = f_out; bus.alu_z = f_z; bus.alu_n = f_n;
    end else begin
      o = m_op[0] ? (m_ax - m_ay) : (m_ax + m_ay);
      o = o ^ (m_two ? m_imm : 4'h0);
      if (m_op[1]) o = ~o;
      if (m_op[2]) o = {o[2:0], o[3]};
      bus.alu_out = o; bus.alu_z = (o == 4'h0); bus.alu_n = o[3];
    end
    model_step();
    @(negedge clk);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset(input logic [1:0] target);
    #1;
    rst_n = 1'b0;
    dbg_sel = target;
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_req", {7'd0, bus.imem_req}, 8'h00);
    check("rst_alu", {bus.alu_op, bus.alu_rx}, 8'h00);
    check("rst_alu2", {bus.alu_ry, bus.alu_mem}, 8'h00);
    check("rst_flags", {6'd0, flag_z, flag_n}, 8'h00);
    check("rst_reg", {4'h0, dbg_data}, 8'h00);
    model_reset();
    run = 1'b0;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_ff_fetch();
    int budget = 1500;
    while (!(m_pc == 8'hFF && m_fetching) && budget > 0) begin
      cycle(1'b1);
      budget--;
    end
    check("reach_pc_ff", pc, 8'hFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; dbg_sel = 2'd0;
    bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
    bus.alu_out = 4'h0; bus.alu_z = 1'b0; bus.alu_n = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("reset_pc", pc, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_req", {7'd0, bus.imem_req}, 8'h00);

    // One-byte instruction 0x16, zero-wait memory.
    mem[0] = 8'h16; force_alu = 1'b1; f_out = 4'h6; f_z = 1'b0; f_n = 1'b0;
    req_seen = 0;
    cycle(1'b1); cycle(1'b0); cycle(1'b0); cycle(1'b0);
    check("i1_pc", pc, 8'h01);
    check("i1_req_cycles", 8'(req_seen), 8'd1);
    check("i1_flags", {6'd0, flag_z, flag_n}, 8'h00);
    check_reg("i1_r1", 2'd1, 4'h6);

    // Two-byte instruction 0x84 0xF9.
    mem[1] = 8'h84; mem[2] = 8'hF9; f_out = 4'h8; f_z = 1'b0; f_n = 1'b1;
    req_seen = 0;
    cycle(1'b1); cycle(1'b0); cycle(1'b0);
    check("i2_alu_mem", {4'h0, bus.alu_mem}, 8'h09);
    check("i2_alu_op", {4'h0, bus.alu_op}, 8'h08);
    check("i2_alu_rx", {4'h0, bus.alu_rx}, 8'h06);
    cycle(1'b0); cycle(1'b0);
    check("i2_pc", pc, 8'h03);
    check("i2_flag_n", {7'd0, flag_n}, 8'h01);
    check("i2_req_cycles", 8'(req_seen), 8'd2);
    check_reg("i2_r1", 2'd1, 4'h8);

    // Three wait states on the fetch.
    mem[3] = 8'h2B; fixed_wait = 3; f_out = 4'hA; f_z = 1'b0; f_n = 1'b1;
    req_seen = 0;
    cycle(1'b1);
    check("w_addr_first", bus.imem_addr, 8'h03);
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    check("w_addr_held", bus.imem_addr, 8'h03);
    check("w_req_held", {7'd0, bus.imem_req}, 8'h01);
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    fixed_wait = 0;
    check("w_pc", pc, 8'h04);
    check("w_req_cycles", 8'(req_seen), 8'd4);
    check_reg("w_r2", 2'd2, 4'hA);

    // run dropped during EXEC: instruction still retires, then idle.
    mem[4] = 8'h3C; f_out = 4'h5; f_z = 1'b0; f_n = 1'b0;
    cycle(1'b1); cycle(1'b1); cycle(1'b0); cycle(1'b0);
    check("drop_busy", {7'd0, busy}, 8'h00);
    check("drop_req", {7'd0, bus.imem_req}, 8'h00);
    check("drop_pc", pc, 8'h05);
    check_reg("drop_r3", 2'd3, 4'h5);
    cycle(1'b0);
    check("drop_req_later", {7'd0, bus.imem_req}, 8'h00);

    // Reset pulsed during EXEC discards the instruction.
    mem[5] = 8'h4E; f_out = 4'hF; f_z = 1'b0; f_n = 1'b1;
    cycle(1'b1); cycle(1'b0);
    check("rx_alu_op", {4'h0, bus.alu_op}, 8'h04);
    async_reset(2'd3);
    cycle(1'b0); cycle(1'b0);
    check("rx_pc", pc, 8'h00);
    check_reg("rx_r3", 2'd3, 4'h0);

    // pc wrap with a one-byte instruction at 0xFF.
    force_alu = 1'b0; fixed_wait = 0;
    for (int a = 0; a < 256; a++) mem[a] = {1'b0, 7'($urandom)};
    mem[8'h00] = 8'h05;
    mem[8'hFF] = 8'h35;
    run_until_ff_fetch();
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    check("wrap1_pc", pc, 8'h00);

    // pc wrap with a two-byte instruction at 0xFF: second byte from 0x00.
    mem[8'hFF] = 8'h9D;
    run_until_ff_fetch();
    cycle(1'b0);
    check("wrap2_addr", bus.imem_addr, 8'h00);
    check("wrap2_req", {7'd0, bus.imem_req}, 8'h01);
    cycle(1'b0);
    check("wrap2_imm", {4'h0, bus.alu_mem}, 8'h05);
    cycle(1'b0); cycle(1'b0);
    check("wrap2_pc", pc, 8'h01);

    // Randomized code, wait states and run toggling, with one reset mid-way.
    fixed_wait = -1;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 5) != 0);
      if (c == 1500) async_reset(2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
